// File: rtl/shuffle_sequencer_if.sv
// Bundle for the shuffle sequencer: the game-logic control handshake plus the
// PRNG / modulo datapath hookup. The master is the environment and the slave is the sequencer.
interface shuffle_sequencer_if #(
  parameter int unsigned N_ITEMS = 10
);
  // Control handshake
  logic                   start_i;
  logic                   abort_i;
  logic [31:0]            seed_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   valid_o;
  logic [4*N_ITEMS-1:0]   perm_o;
  logic                   err_o;
  // PRNG / modulo datapath
  logic [31:0]            rng_seed_o;
  logic                   rng_load_o;
  logic [3:0]             rng_limit_o;
  logic [3:0]             rng_value_i;

  modport master (
    output start_i, abort_i, seed_i, rng_value_i,
    input  busy_o, done_o, valid_o, perm_o, err_o, rng_seed_o, rng_load_o, rng_limit_o
  );

  modport slave (
    input  start_i, abort_i, seed_i, rng_value_i,
    output busy_o, done_o, valid_o, perm_o, err_o, rng_seed_o, rng_load_o, rng_limit_o
  );
endinterface

// File: rtl/shuffle_sequencer.sv
// Fisher-Yates shuffle controller. It seeds an external xorshift PRNG, then sweeps
// i = N_ITEMS-1 down to 1. On each step it asks the modulo datapath for j in [0,i] and
// exchanges entries i and j within a single cycle, so perm_o is always a permutation.
// Optional feature: define SHUFFLE_CHECK_EN so that an out-of-range j raises a sticky err_o and
// skips the swap. When the macro is undefined, err_o is tied low and j is folded modulo N_ITEMS.
module shuffle_sequencer #(
  parameter int unsigned N_ITEMS   = 10,
  parameter logic [31:0] ZERO_SEED = 32'h2545_F491
) (
  input logic                clk_i,
  input logic                nreset_i,
  shuffle_sequencer_if.slave bus_io
);

  localparam logic [3:0] LastIdx = 4'(N_ITEMS - 1);

  typedef enum logic [1:0] {StIdle, StSeed, StSwap, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  perm_q [N_ITEMS];
  logic [3:0]  perm_d [N_ITEMS];
  logic [31:0] seed_q, seed_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        load_q, load_d;
  logic [3:0]  limit_q, limit_d;
  logic [3:0]  j_eff;

`ifdef SHUFFLE_CHECK_EN
  logic        err_q, err_d;
  logic        j_bad;

  // Reject j > i: flag it and degrade the step to a no-op swap.
  always_comb begin
    j_bad = (bus_io.rng_value_i > idx_q);
    j_eff = j_bad ? idx_q : bus_io.rng_value_i;
  end
`else
  // Trust the datapath, but fold j into range so the result stays a permutation.
  always_comb begin
    j_eff = 4'(32'(bus_io.rng_value_i) % N_ITEMS);
  end
`endif

  // Next-state, the swap datapath, and the next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    perm_d  = perm_q;
    seed_d  = seed_q;
    valid_d = valid_q;
`ifdef SHUFFLE_CHECK_EN
    err_d   = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus_io.start_i && !bus_io.abort_i) begin
          seed_d  = (bus_io.seed_i == 32'd0) ? ZERO_SEED : bus_io.seed_i;
          valid_d = 1'b0;
          state_d = StSeed;
        end
      end
      StSeed: begin
        for (int k = 0; k < N_ITEMS; k++) begin
          perm_d[k] = 4'(k);
        end
        idx_d   = LastIdx;
        state_d = StSwap;
      end
      StSwap: begin
        perm_d[idx_q] = perm_q[j_eff];
        perm_d[j_eff] = perm_q[idx_q];
        idx_d         = idx_q - 4'd1;
`ifdef SHUFFLE_CHECK_EN
        err_d         = err_q | j_bad;
`endif
        if (idx_q == 4'd1) begin
          valid_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort freezes the array where it stands and drops validity; no done pulse follows.
    if (bus_io.abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      idx_d   = idx_q;
      perm_d  = perm_q;
      valid_d = 1'b0;
`ifdef SHUFFLE_CHECK_EN
      err_d   = err_q;
`endif
    end

    // Outputs are decoded from the next state so that they are registered yet cycle-aligned.
    busy_d  = (state_d == StSeed) || (state_d == StSwap);
    done_d  = (state_d == StDone);
    load_d  = (state_d == StSeed);
    limit_d = (state_d == StSwap) ? idx_d : 4'd0;
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      for (int k = 0; k < N_ITEMS; k++) begin
        perm_q[k] <= 4'(k);
      end
      seed_q  <= 32'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      limit_q <= 4'd0;
`ifdef SHUFFLE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      perm_q  <= perm_d;
      seed_q  <= seed_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      limit_q <= limit_d;
`ifdef SHUFFLE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  for (genvar k = 0; k < N_ITEMS; k++) begin : g_perm_out
    assign bus_io.perm_o[4*k +: 4] = perm_q[k];
  end

  assign bus_io.busy_o      = busy_q;
  assign bus_io.done_o      = done_q;
  assign bus_io.valid_o     = valid_q;
  assign bus_io.rng_seed_o  = seed_q;
  assign bus_io.rng_load_o  = load_q;
  assign bus_io.rng_limit_o = limit_q;
`ifdef SHUFFLE_CHECK_EN
  assign bus_io.err_o       = err_q;
`else
  assign bus_io.err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_shuffle_sequencer.sv
// Testbench for shuffle_sequencer. The random source is either a table of j values indexed by
// the requested limit or a behavioural xorshift32 PRNG. The expected permutations come from
// a plain Fisher-Yates reference model.
module tb_shuffle_sequencer;

  localparam int          N          = 10;
  localparam logic [31:0] ZERO       = 32'h2545_F491;
  localparam int          RUN_CYCLES = 24;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  shuffle_sequencer_if #(.N_ITEMS(N)) bus ();

  shuffle_sequencer #(
    .N_ITEMS  (N),
    .ZERO_SEED(ZERO)
  ) dut (
    .clk_i   (clk),
    .nreset_i(nreset),
    .bus_io  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Random source: a j table indexed by the requested limit, or the xorshift PRNG.
  int          jm [16];
  logic        use_prng = 1'b0;
  logic [31:0] prng_st = 32'd0;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  always @(posedge clk) begin
    if (bus.rng_load_o) prng_st <= bus.rng_seed_o;
    else if (bus.busy_o) prng_st <= xs(prng_st);
  end

  always_comb begin
    bus.rng_value_i = 4'd0;
    if (use_prng) bus.rng_value_i = 4'(prng_st % (32'(bus.rng_limit_o) + 32'd1));
    else bus.rng_value_i = 4'(jm[bus.rng_limit_o]);
  end

  // Reference model
  int exp_perm [N];

  // Apply Fisher-Yates steps i = N-1 down to stop_i, using j values from jm.
  function automatic void model(input int stop_i);
    int t, j;
    for (int k = 0; k < N; k++) exp_perm[k] = k;
    for (int i = N - 1; i >= stop_i; i--) begin
      j = jm[i];
`ifdef SHUFFLE_CHECK_EN
      if (j > i) j = i;
`else
      j = j % N;
`endif
      t = exp_perm[i];
      exp_perm[i] = exp_perm[j];
      exp_perm[j] = t;
    end
  endfunction

  function automatic logic [4*N-1:0] exp_word();
    logic [4*N-1:0] w;
    for (int k = 0; k < N; k++) w[4*k +: 4] = 4'(exp_perm[k]);
    return w;
  endfunction

  function automatic logic is_perm(input logic [4*N-1:0] w);
    int cnt [16];
    logic [3:0] e;
    for (int k = 0; k < 16; k++) cnt[k] = 0;
    for (int k = 0; k < N; k++) begin
      e = w[4*k +: 4];
      cnt[e]++;
    end
    for (int k = 0; k < N; k++) if (cnt[k] != 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void prng_model(input logic [31:0] seed);
    logic [31:0] st;
    st = (seed == 32'd0) ? ZERO : seed;
    for (int i = N - 1; i >= 1; i--) begin
      jm[i] = int'(st % (i + 1));
      st = xs(st);
    end
    model(1);
  endfunction

  // Observations recorded during a run
  int          lim_q [$];
  int          load_cnt, done_cnt, lat;
  logic [31:0] seed_seen;
  logic        busy_hist [RUN_CYCLES];
  logic        valid_hist [RUN_CYCLES];
  logic        err_hist [RUN_CYCLES];

  // Start a shuffle (accepted at edge 0) and record RUN_CYCLES cycles of outputs.
  // abort_c / poke_c: cycle during which abort_i / an extra start_i is held high (0 = never).
  task automatic run_shuffle(input logic [31:0] seed, input int abort_c, input int poke_c);
    lim_q.delete();
    load_cnt  = 0;
    done_cnt  = 0;
    lat       = -1;
    seed_seen = 32'd0;
    @(negedge clk);
    bus.seed_i  = seed;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int c = 1; c < RUN_CYCLES; c++) begin
      busy_hist[c]  = bus.busy_o;
      valid_hist[c] = bus.valid_o;
      err_hist[c]   = bus.err_o;
      if (bus.rng_load_o) begin
        load_cnt++;
        seed_seen = bus.rng_seed_o;
      end
      if (bus.rng_limit_o != 4'd0) lim_q.push_back(int'(bus.rng_limit_o));
      if (bus.done_o) begin
        done_cnt++;
        if (lat < 0) lat = c;
      end
      bus.abort_i = (c == abort_c);
      bus.start_i = (c == poke_c);
      @(negedge clk);
    end
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.seed_i  = 32'd0;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    model(N);
    checks++;
    if (bus.perm_o !== exp_word()) begin
      errors++;
      $display("FAIL reset_perm: got %h, expected %h", bus.perm_o, exp_word());
    end
    checks++;
    if ({bus.busy_o, bus.done_o, bus.valid_o, bus.err_o, bus.rng_load_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {bus.busy_o, bus.done_o, bus.valid_o, bus.err_o, bus.rng_load_o});
    end
    checks++;
    if ({bus.rng_limit_o, bus.rng_seed_o} !== 36'd0) begin
      errors++;
      $display("FAIL reset_rng: got limit %0d seed %h, expected 0 0", bus.rng_limit_o,
               bus.rng_seed_o);
    end
  endtask

  task automatic test_zero_stub();
    logic [4*N-1:0] want;
    use_prng = 1'b0;
    for (int k = 0; k < 16; k++) jm[k] = 0;
    run_shuffle(32'd1, 0, 0);
    for (int k = 0; k < N; k++) want[4*k +: 4] = 4'((k + 1) % N);
    checks++;
    if (lat !== N + 1) begin
      errors++;
      $display("FAIL zero_latency: got %0d, expected %0d", lat, N + 1);
    end
    checks++;
    if (bus.perm_o !== want) begin
      errors++;
      $display("FAIL zero_perm: got %h, expected %h", bus.perm_o, want);
    end
    checks++;
    if ({bus.valid_o, load_cnt == 1, done_cnt == 1} !== 3'b111) begin
      errors++;
      $display("FAIL zero_flags: got valid %b loads %0d dones %0d, expected 1 1 1", bus.valid_o,
               load_cnt, done_cnt);
    end
    checks++;
    if (seed_seen !== 32'd1) begin
      errors++;
      $display("FAIL zero_seed: got %h, expected 00000001", seed_seen);
    end
  endtask

  task automatic test_identity_stub();
    int want_lim [$];
    use_prng = 1'b0;
    for (int k = 0; k < 16; k++) jm[k] = k;
    for (int i = N - 1; i >= 1; i--) want_lim.push_back(i);
    run_shuffle(32'hDEAD_BEEF, 0, 0);
    model(N);
    checks++;
    if (bus.perm_o !== exp_word()) begin
      errors++;
      $display("FAIL ident_perm: got %h, expected %h", bus.perm_o, exp_word());
    end
    checks++;
    if (lim_q != want_lim) begin
      errors++;
      $display("FAIL ident_limits: got %p, expected %p", lim_q, want_lim);
    end
    checks++;
    if (load_cnt !== 1) begin
      errors++;
      $display("FAIL ident_load: got %0d cycles, expected 1", load_cnt);
    end
  endtask

  task automatic test_random();
    use_prng = 1'b0;
    for (int it = 0; it < 5; it++) begin
      for (int k = 0; k < 16; k++) jm[k] = 0;
      for (int i = 1; i < N; i++) jm[i] = int'($urandom_range(0, i));
      run_shuffle($urandom, 0, 0);
      model(1);
      checks++;
      if (bus.perm_o !== exp_word()) begin
        errors++;
        $display("FAIL random_perm[%0d]: got %h, expected %h", it, bus.perm_o, exp_word());
      end
      checks++;
      if (lat !== N + 1 || bus.valid_o !== 1'b1) begin
        errors++;
        $display("FAIL random_done[%0d]: got lat %0d valid %b, expected %0d 1", it, lat,
                 bus.valid_o, N + 1);
      end
    end
  endtask

  task automatic test_prng();
    logic [4*N-1:0] first;
    use_prng = 1'b1;
    run_shuffle(32'd0, 0, 0);
    first = bus.perm_o;
    prng_model(32'd0);
    checks++;
    if (seed_seen !== ZERO) begin
      errors++;
      $display("FAIL prng_seed: got %h, expected %h", seed_seen, ZERO);
    end
    checks++;
    if (bus.perm_o !== exp_word() || is_perm(bus.perm_o) !== 1'b1) begin
      errors++;
      $display("FAIL prng_perm: got %h, expected %h", bus.perm_o, exp_word());
    end
    run_shuffle(32'd0, 0, 0);
    checks++;
    if (bus.perm_o !== first) begin
      errors++;
      $display("FAIL prng_repeat: got %h, expected %h", bus.perm_o, first);
    end
    use_prng = 1'b0;
  endtask

  task automatic test_abort();
    use_prng = 1'b0;
    for (int k = 0; k < 16; k++) jm[k] = 0;
    for (int i = 1; i < N; i++) jm[i] = int'($urandom_range(0, i - 1));
    // SWAP cycles are 2, 3, 4, so abort during cycle 4 stops after steps i=9 and i=8.
    run_shuffle($urandom, 4, 0);
    model(N - 2);
    checks++;
    if ({busy_hist[5], valid_hist[5]} !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle: got busy %b valid %b, expected 0 0", busy_hist[5],
               valid_hist[5]);
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_done: got %0d pulses, expected 0", done_cnt);
    end
    checks++;
    if (bus.perm_o !== exp_word()) begin
      errors++;
      $display("FAIL abort_partial: got %h, expected %h", bus.perm_o, exp_word());
    end
  endtask

  task automatic test_start_ignored();
    use_prng = 1'b0;
    for (int i = 1; i < N; i++) jm[i] = int'($urandom_range(0, i));
    run_shuffle($urandom, 0, 5);
    model(1);
    checks++;
    if (done_cnt !== 1 || lat !== N + 1) begin
      errors++;
      $display("FAIL busy_start: got dones %0d lat %0d, expected 1 %0d", done_cnt, lat, N + 1);
    end
    checks++;
    if (bus.perm_o !== exp_word()) begin
      errors++;
      $display("FAIL busy_start_perm: got %h, expected %h", bus.perm_o, exp_word());
    end
  endtask

  task automatic test_abort_vs_start();
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    bus.seed_i  = 32'h1234_5678;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    checks++;
    if ({bus.busy_o, bus.rng_load_o} !== 2'b00) begin
      errors++;
      $display("FAIL abort_wins: got busy %b load %b, expected 0 0", bus.busy_o,
               bus.rng_load_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_wins_late: got busy %b, expected 0", bus.busy_o);
    end
  endtask

  task automatic test_out_of_range();
    use_prng = 1'b0;
    for (int k = 0; k < 16; k++) jm[k] = 15;
    run_shuffle(32'd7, 0, 0);
    model(1);
`ifdef SHUFFLE_CHECK_EN
    checks++;
    if ({err_hist[2], err_hist[3]} !== 2'b01) begin
      errors++;
      $display("FAIL oor_err: got cyc2 %b cyc3 %b, expected 0 1", err_hist[2], err_hist[3]);
    end
`else
    checks++;
    if (err_hist[3] !== 1'b0 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL oor_err: got %b, expected 0", bus.err_o);
    end
`endif
    checks++;
    if (bus.perm_o !== exp_word() || is_perm(bus.perm_o) !== 1'b1) begin
      errors++;
      $display("FAIL oor_perm: got %h, expected %h", bus.perm_o, exp_word());
    end
  endtask

  task automatic test_async_reset();
    use_prng = 1'b0;
    for (int k = 0; k < 16; k++) jm[k] = 0;
    @(negedge clk);
    bus.seed_i  = 32'h5;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    model(N);
    checks++;
    if ({bus.busy_o, bus.valid_o, bus.err_o, bus.rng_load_o, bus.rng_limit_o} !== 8'd0) begin
      errors++;
      $display("FAIL async_flags: got busy %b valid %b err %b load %b limit %0d, expected 0",
               bus.busy_o, bus.valid_o, bus.err_o, bus.rng_load_o, bus.rng_limit_o);
    end
    checks++;
    if (bus.perm_o !== exp_word() || bus.rng_seed_o !== 32'd0) begin
      errors++;
      $display("FAIL async_perm: got %h seed %h, expected %h seed 0", bus.perm_o,
               bus.rng_seed_o, exp_word());
    end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) jm[k] = 0;
    test_reset();
    test_zero_stub();
    test_identity_stub();
    test_random();
    test_prng();
    test_abort();
    test_start_ignored();
    test_abort_vs_start();
    test_out_of_range();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a task stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
